// File: rtl/uart_pkg.sv
// Shared types and register map for the UART receive path.
// STATUS layout: [0] !empty, [1] frame_err, [2] overrun, [3] parity_err,
// [4] reserved (0), [5] full.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic [4:0] RXDATA_OFS = 5'h00;
  localparam logic [4:0] STATUS_OFS = 5'h04;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_FRAME   = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_PARITY  = 3;
  localparam int ST_FULL    = 5;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. A pop on an empty FIFO is
// ignored; a push on a full FIFO is accepted only if a pop frees a slot in
// the same clock. Empty flag is registered so the interrupt is glitch-free.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = empty_q;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/count.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    empty_d  = (count_d == '0);
  end

  // Pointer, count and empty-flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  // Storage; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: 2-flop synchroniser, 8N1 deserialiser FSM on the 16x
// s_tick, receive FIFO and a CPU read port (RXDATA pops, STATUS clears
// sticky errors). rx_irq is high while received data is waiting.
// Optional even-parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_tick,
  input  logic        rx,
  input  logic [4:0]  cpu_address,
  input  logic        cpu_rd_en,
  output logic [31:0] cpu_rdata,
  output logic        rx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            rx_meta_q, rx_s_q;
  rx_state_e       state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            parity_err_q, parity_err_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic [31:0]     status_word;
  logic            push, frame_evt, par_evt, overrun_evt;
  logic            pop_req, status_rd;
  logic [DBIT-1:0] fifo_dout;
  logic            fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
`endif

  // Bring the asynchronous line into the clk domain; idle level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame deserialiser next state; events are one-clk pulses.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    par_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == 3'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d       = '0;
            par_bad_d = ^{b_q, rx_s_q};
            par_evt   = ^{b_q, rx_s_q};
            state_d   = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK-1)) begin
            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad_q;
`else
              push = 1'b1;
`endif
            end else begin
              frame_evt = 1'b1;
            end
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Deserialiser state registers; reset discards any partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(DBIT)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   (b_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Register decode, sticky error update and read-data mux.
  always_comb begin
    pop_req     = cpu_rd_en && (cpu_address == RXDATA_OFS) && !fifo_empty;
    status_rd   = cpu_rd_en && (cpu_address == STATUS_OFS);
    overrun_evt = push && fifo_full && !pop_req;

    // A same-clk error event beats the clear-on-read.
    frame_err_d  = (frame_err_q  && !status_rd) || frame_evt;
    overrun_d    = (overrun_q    && !status_rd) || overrun_evt;
    parity_err_d = (parity_err_q && !status_rd) || par_evt;

    status_word              = '0;
    status_word[ST_NEMPTY]   = !fifo_empty;
    status_word[ST_FRAME]    = frame_err_q;
    status_word[ST_OVERRUN]  = overrun_q;
    status_word[ST_PARITY]   = parity_err_q;
    status_word[ST_FULL]     = (fifo_count == CW'(FIFO_DEPTH));

    cpu_rdata_d = cpu_rdata_q;
    if (cpu_rd_en) begin
      case (cpu_address)
        RXDATA_OFS: cpu_rdata_d = fifo_empty ? '0 : {{(32-DBIT){1'b0}}, fifo_dout};
        STATUS_OFS: cpu_rdata_d = status_word;
        default:    cpu_rdata_d = '0;
      endcase
    end
  end

  // Status flags and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign rx_irq    = !fifo_empty;

endmodule
